// File: rtl/binary_mul_pipe_param.sv
// binary_mul_pipe_param: row-pipelined array multiplier with carry-save reduction.
//
// Each pipeline stage folds one partial-product row of B into a carry-save
// (sum, carry) pair. A final carry-propagate stage loads the exact product.
// Operands, mode, tag and valid travel with their data, so a new operation can
// be issued on every cycle. The en input freezes every register in the block.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst_n     synchronous active-low reset
//   en        global advance enable; 0 holds every pipeline register
//   in_valid  operand pair present (accepted when en=1)
//   in_ready  combinational copy of en
//   in_signed 1 = two's-complement A and B, 0 = unsigned
//   A, B      multiplicand / multiplier
//   in_tag    user tag carried with the operation
//   out_valid P/out_tag hold a newly produced result
//   P         exact WIDTH_A+WIDTH_B bit product
//   out_tag   tag of the result in P
//
// Latency is WIDTH_B+1 enabled edges from acceptance to out_valid.

module binary_mul_pipe_param #(
    parameter int unsigned WIDTH_A = 8,
    parameter int unsigned WIDTH_B = 8,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_signed,
    input  logic [WIDTH_A-1:0]         A,
    input  logic [WIDTH_B-1:0]         B,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    output logic [WIDTH_A+WIDTH_B-1:0] P,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int unsigned N = WIDTH_A + WIDTH_B;

    // Partial-product row for multiplier bit position sh. In signed mode the
    // top row carries negative weight, so it adds the negated extended A. The
    // negation is done at full width, which keeps A = -2^(WIDTH_A-1) exact.
    function automatic logic [N-1:0] pp_row(input logic [WIDTH_A-1:0] a,
                                            input logic               sgn,
                                            input logic               bit_k,
                                            input int unsigned        sh,
                                            input logic               last);
        logic [N-1:0] a_ext;
        logic [N-1:0] a_neg;
        a_ext = sgn ? {{WIDTH_B{a[WIDTH_A-1]}}, a} : {{WIDTH_B{1'b0}}, a};
        a_neg = ~a_ext + N'(1);
        if (!bit_k) begin
            return '0;
        end else if (sgn && last) begin
            return a_neg << sh;
        end else begin
            return a_ext << sh;
        end
    endfunction

    assign in_ready = en;

    for (genvar k = 0; k < WIDTH_B; k++) begin : g_st
        logic               vld_q, vld_d;
        logic               sgn_q, sgn_d;
        logic [WIDTH_A-1:0] a_q, a_d;
        logic [WIDTH_B-1:0] b_q, b_d;
        logic [TAG_W-1:0]   tag_q, tag_d;
        logic [N-1:0]       sum_q, sum_d;
        logic [N-1:0]       carry_q, carry_d;

        if (k == 0) begin : g_first
            // Unaccepted inputs are zeroed so X never enters the pipeline.
            always_comb begin
                vld_d   = in_valid;
                sgn_d   = in_valid ? in_signed : 1'b0;
                a_d     = in_valid ? A : '0;
                b_d     = in_valid ? B : '0;
                tag_d   = in_valid ? in_tag : '0;
                sum_d   = pp_row(a_d, sgn_d, b_d[0], 0, 1'b0);
                carry_d = '0;
            end
        end else begin : g_rest
            logic [N-1:0] row;
            logic [N-1:0] maj;

            always_comb begin
                vld_d   = g_st[k-1].vld_q;
                sgn_d   = g_st[k-1].sgn_q;
                a_d     = g_st[k-1].a_q;
                b_d     = g_st[k-1].b_q;
                tag_d   = g_st[k-1].tag_q;
                row     = pp_row(a_d, sgn_d, b_d[k], k, (k == WIDTH_B - 1));
                // 3:2 compression; carries past bit N-1 fall off (mod 2^N).
                sum_d   = g_st[k-1].sum_q ^ g_st[k-1].carry_q ^ row;
                maj     = (g_st[k-1].sum_q & g_st[k-1].carry_q) |
                          (g_st[k-1].sum_q & row) |
                          (g_st[k-1].carry_q & row);
                carry_d = {maj[N-2:0], 1'b0};
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                sgn_q   <= 1'b0;
                a_q     <= '0;
                b_q     <= '0;
                tag_q   <= '0;
                sum_q   <= '0;
                carry_q <= '0;
            end else if (en) begin
                vld_q   <= vld_d;
                sgn_q   <= sgn_d;
                a_q     <= a_d;
                b_q     <= b_d;
                tag_q   <= tag_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        // Later stages read only some operand bits; the rest are intentionally idle.
        logic unused_stage;
        assign unused_stage = ^{a_q, b_q, sgn_q};
    end

    // Final carry-propagate stage.
    logic               out_valid_q;
    logic [N-1:0]       p_q, p_d;
    logic [TAG_W-1:0]   out_tag_q;
    logic               last_vld;

    assign last_vld = g_st[WIDTH_B-1].vld_q;
    assign p_d      = g_st[WIDTH_B-1].sum_q + g_st[WIDTH_B-1].carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            out_valid_q <= last_vld;
            // Bubbles leave the previous result in place.
            if (last_vld) begin
                p_q       <= p_d;
                out_tag_q <= g_st[WIDTH_B-1].tag_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign P         = p_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_binary_mul_pipe_param.sv
// Bench for binary_mul_pipe_param: directed checks on the default 8x8 build and a
// random regression on both the 8x8 and a 5x7 build against an arithmetic model.

module tb_binary_mul_pipe_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, in_valid, in_signed;
    logic [7:0] a, b;
    logic [3:0] tag;

    logic        rdy0, ov0;
    logic [15:0] p0;
    logic [3:0]  ot0;
    logic        rdy1, ov1;
    logic [11:0] p1;
    logic [3:0]  ot1;

    binary_mul_pipe_param #(.WIDTH_A(8), .WIDTH_B(8), .TAG_W(4)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (rdy0),
        .in_signed (in_signed),
        .A         (a),
        .B         (b),
        .in_tag    (tag),
        .out_valid (ov0),
        .P         (p0),
        .out_tag   (ot0)
    );

    binary_mul_pipe_param #(.WIDTH_A(5), .WIDTH_B(7), .TAG_W(4)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (rdy1),
        .in_signed (in_signed),
        .A         (a[4:0]),
        .B         (b[6:0]),
        .in_tag    (tag),
        .out_valid (ov1),
        .P         (p1),
        .out_tag   (ot1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Exact product of wa-bit a and wb-bit b, reduced to wa+wb bits.
    function automatic longint ref_mul(input longint av, input longint bv, input bit s,
                                       input int wa, input int wb);
        longint x, y;
        x = av;
        y = bv;
        if (s) begin
            if (x >= (longint'(1) << (wa - 1))) x = x - (longint'(1) << wa);
            if (y >= (longint'(1) << (wb - 1))) y = y - (longint'(1) << wb);
        end
        return (x * y) & ((longint'(1) << (wa + wb)) - 1);
    endfunction

    // Scoreboard: results counted only when out_valid && en.
    bit     sb_on = 1'b0;
    longint q_p0[$], q_t0[$], q_p1[$], q_t1[$];

    always @(negedge clk) begin
        if (sb_on) begin
            if (ov0 && en) begin
                if (q_p0.size() == 0) begin
                    check("sb0_spurious", ov0, 0);
                end else begin
                    check("sb0_p", p0, q_p0.pop_front());
                    check("sb0_tag", ot0, q_t0.pop_front());
                end
            end
            if (ov1 && en) begin
                if (q_p1.size() == 0) begin
                    check("sb1_spurious", ov1, 0);
                end else begin
                    check("sb1_p", p1, q_p1.pop_front());
                    check("sb1_tag", ot1, q_t1.pop_front());
                end
            end
            if (in_valid && en) begin
                q_p0.push_back(ref_mul(longint'(a), longint'(b), in_signed, 8, 8));
                q_t0.push_back(longint'(tag));
                q_p1.push_back(ref_mul(longint'(a[4:0]), longint'(b[6:0]), in_signed, 5, 7));
                q_t1.push_back(longint'(tag));
            end
        end
    end

    // Issue one op at the current cycle, then expect it after exactly 9 edges.
    task automatic run_one(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                           input logic [3:0] tt, input logic [15:0] ep, input string nm);
        a = ta; b = tb_v; in_signed = ts; tag = tt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check({nm, "_early"}, ov0, 0);
        @(posedge clk); #1;
        check({nm, "_valid"}, ov0, 1);
        check({nm, "_p"}, p0, ep);
        check({nm, "_tag"}, ot0, tt);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
        a = '0; b = '0; tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ov0, 0);
        check("rst_p", p0, 0);
        check("rst_tag", ot0, 0);
        check("rst_valid_w57", ov1, 0);
        rst_n = 1'b1;

        // Signed corners.
        run_one(8'h80, 8'h80, 1'b1, 4'd3, 16'h4000, "s_min_min");
        run_one(8'hFF, 8'h01, 1'b1, 4'd7, 16'hFFFF, "s_m1_p1");

        // Unsigned back-to-back.
        in_signed = 1'b0; in_valid = 1'b1;
        a = 8'd255; b = 8'd255; tag = 4'd0; @(posedge clk); #1;
        a = 8'd0;   b = 8'd200; tag = 4'd1; @(posedge clk); #1;
        a = 8'd13;  b = 8'd11;  tag = 4'd2; @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("ub_early", ov0, 0);
        @(posedge clk); #1;
        check("ub0_valid", ov0, 1); check("ub0_p", p0, 16'hFE01); check("ub0_tag", ot0, 0);
        @(posedge clk); #1;
        check("ub1_valid", ov0, 1); check("ub1_p", p0, 16'h0000); check("ub1_tag", ot0, 1);
        @(posedge clk); #1;
        check("ub2_valid", ov0, 1); check("ub2_p", p0, 16'h008F); check("ub2_tag", ot0, 2);
        @(posedge clk); #1;
        check("ub_after", ov0, 0);

        // Mixed mode back-to-back, same operands.
        a = 8'hFF; b = 8'h02; in_signed = 1'b1; tag = 4'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_signed = 1'b0; tag = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mix_s_valid", ov0, 1); check("mix_s_p", p0, 16'hFFFE); check("mix_s_tag", ot0, 4);
        @(posedge clk); #1;
        check("mix_u_valid", ov0, 1); check("mix_u_p", p0, 16'h01FE); check("mix_u_tag", ot0, 5);

        // Stall after 3 enabled edges, 5 frozen edges, inputs ignored meanwhile.
        a = 8'd7; b = 8'd9; in_signed = 1'b0; tag = 4'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        a = 8'hAA; b = 8'h55; tag = 4'd9; in_valid = 1'b1;
        #1;
        check("stall_ready_lo", rdy0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", ov0, 0);
            check("stall_p_hold", p0, 16'h01FE);
        end
        in_valid = 1'b0; en = 1'b1;
        #1;
        check("stall_ready_hi", rdy0, 1);
        repeat (5) @(posedge clk);
        #1;
        check("stall_early", ov0, 0);
        @(posedge clk); #1;
        check("stall_res_valid", ov0, 1);
        check("stall_res_p", p0, 16'h003F);
        check("stall_res_tag", ot0, 6);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("freeze_valid", ov0, 1);
        check("freeze_p", p0, 16'h003F);
        en = 1'b1;
        @(posedge clk); #1;
        check("bubble_valid", ov0, 0);
        check("bubble_p_hold", p0, 16'h003F);

        // Reset with four ops in flight.
        in_signed = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 8'(i + 1); b = 8'd3; tag = 4'(i + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", ov0, 0);
        check("midrst_p", p0, 0);
        check("midrst_tag", ot0, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ov0 || ov1) seen = 1'b1;
        end
        check("midrst_no_ghost", seen, 0);

        // Random regression on both builds.
        q_p0.delete(); q_t0.delete(); q_p1.delete(); q_t1.delete();
        sb_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            en        = ($urandom_range(0, 9) < 8);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_signed = 1'($urandom);
            a         = ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom);
            b         = ($urandom_range(0, 15) == 0) ? 8'hC0 : 8'($urandom);
            tag       = 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("drain_q0", q_p0.size(), 0);
        check("drain_q1", q_p1.size(), 0);
        sb_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_mul_pipe_param.md
Name: binary_mul_pipe_param

Overview:
- Parametrised, row-pipelined array multiplier for the Binary_mul family.
- One partial-product row of B is reduced per pipeline stage in carry-save form, and a final carry-propagate stage produces the product.
- Successor to the fixed 6x6 signed array. Adds independent A/B widths, a per-operation signed/unsigned mode, an exact full-width product, a valid/tag pipeline and a real stall enable.
- Operands travel with their data, so back-to-back issue every cycle is legal.

Parameters:
- WIDTH_A, 8, multiplicand width (>=2).
- WIDTH_B, 8, multiplier width (>=2); sets pipeline depth.
- TAG_W, 4, user tag width carried alongside each operation (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  global advance enable; 0 freezes every pipeline register.
- in_valid  in  1  operand pair present.
- in_ready  out  1  combinational copy of en.
- in_signed  in  1  1 = two's-complement A and B, 0 = unsigned.
- A  in  WIDTH_A  multiplicand.
- B  in  WIDTH_B  multiplier.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  P/out_tag hold a result.
- P  out  WIDTH_A+WIDTH_B  exact product.
- out_tag  out  TAG_W  tag of the result in P.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: every stage valid bit, out_valid, P and out_tag go to 0 on the first rising edge with rst_n=0.
  - Reset mid-operation discards all in-flight operations; no partial results appear after release.
- Acceptance: an operation is accepted on an edge where in_valid=1 and en=1. in_ready=en at all times.
- Pipeline: D = WIDTH_B+1 register stages.
  - Stage 0 registers row 0 together with A, B, in_signed, tag and valid.
  - Stage k (1..WIDTH_B-1) adds row k into the carry-save sum/carry vectors, each WIDTH_A+WIDTH_B wide.
  - Stage D-1 performs the carry-propagate add and loads P, out_tag and out_valid.
- Latency: with en held 1, an operation presented in cycle t appears with out_valid=1 in cycle t+D. Throughput is 1 per cycle.
- Stall (en=0): all stage registers, P, out_tag and out_valid hold their values; inputs are ignored.
  - Downstream counts a result only on cycles with out_valid=1 and en=1.
  - A stalled out_valid therefore represents the same single result.
- Output update: at each enabled edge, out_valid takes the last-stage valid bit.
  - P/out_tag load only when that bit is 1; otherwise they hold the previous result.
  - Bubbles do not disturb P.
- Unsigned arithmetic: A and B are zero-extended to WIDTH_A+WIDTH_B and rows are added. P = A*B exactly.
- Signed arithmetic:
  - Rows 0..WIDTH_B-2 use A sign-extended to WIDTH_A+WIDTH_B.
  - Row WIDTH_B-1 (the B sign bit) subtracts: it adds the two's complement of sign-extended A, shifted by WIDTH_B-1.
  - The complement is formed on the full extended width, so A = -2^(WIDTH_A-1) is handled exactly.
  - P is the exact two's-complement product. Carries out of bit WIDTH_A+WIDTH_B-1 are dropped.
- Per-operation mode: in_signed is captured at acceptance and travels with the operation. Mixed signed/unsigned streams are legal back-to-back.
- Values: no X may propagate from unaccepted inputs; bubble stages may carry don't-care data but valid=0.

Test Plan:
- Defaults, en=1, signed. A=-128, B=-128, tag=3 at cycle t -> cycle t+9: out_valid=1, P=16'h4000, out_tag=3. A=-1, B=1 -> P=16'hFFFF.
- Unsigned, back-to-back every cycle: (255,255), (0,200), (13,11), tags 0,1,2 -> three consecutive out_valid cycles with P = 16'hFE01, 16'h0000, 16'h008F, tags in order.
- Mixed mode, consecutive cycles: A=8'hFF, B=8'h02 with signed=1, then the same operands with signed=0 -> P=16'hFFFE then P=16'h01FE.
- Stall: issue one op, drop en for 5 cycles after 3 enabled edges, then restore -> result appears exactly 9 enabled edges after issue. P/out_valid frozen during the stall. in_ready mirrors en.
- Reset mid-flight: issue 4 ops, assert rst_n=0 for one edge after 4 cycles -> out_valid, P, out_tag = 0 next cycle. No result from the discarded ops ever appears.
- Random regression for WIDTH_A=5, WIDTH_B=7 and defaults: 10k random operands, modes, bubbles and en toggles -> every counted result matches a reference product in issue order.
